// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Reset constants live here so the top level and any sibling blocks agree on them.
package uart_pkg;

  localparam int UART_DATA_WIDTH   = 32;
  localparam int ARB_NUM_REQ       = 4;
  localparam int ARB_START_TIMEOUT = 4;

  // START_TIMEOUT is bounded to 1..255, so an 8-bit counter always suffices.
  localparam int TIMEOUT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  localparam arb_state_t ARB_RST_STATE = IDLE;
  localparam logic       ARB_RST_FLAG  = 1'b0;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: the first set request after the pointer wins.
// The search wraps modulo NUM_REQ, so the pointer's own index has lowest priority.
module rr_priority_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     pointer,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDW-1:0]     index,
  output logic               valid
);

  logic [IDW-1:0] cand;

  always_comb begin
    winner = '0;
    index  = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDW'((32'(pointer) + off) % NUM_REQ);
      if (!valid && req[cand]) begin
        valid        = 1'b1;
        winner[cand] = 1'b1;
        index        = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ clients.
// Launches one frame at a time and recovers via a start timeout if the UART never goes busy.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = ARB_NUM_REQ,
  parameter int DATA_WIDTH    = UART_DATA_WIDTH,
  parameter int START_TIMEOUT = ARB_START_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         uart_tx_data,
  output logic                          uart_tx_req,
  input  logic                          uart_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]    active_id,
  output logic                          arb_busy,
  output logic                          timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW-1:0]           PTR_RST   = IDW'(NUM_REQ - 1);
  localparam logic [TIMEOUT_CNT_W-1:0] CNT_LIMIT = TIMEOUT_CNT_W'(START_TIMEOUT - 1);

  arb_state_t               state;
  logic [IDW-1:0]           pointer;
  logic [TIMEOUT_CNT_W-1:0] start_cnt;

  logic [NUM_REQ-1:0]    pick_onehot;
  logic [IDW-1:0]        pick_index;
  logic                  pick_valid;
  logic [DATA_WIDTH-1:0] pick_word;
  logic [NUM_REQ-1:0]    owner_onehot;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req     (req),
    .pointer (pointer),
    .winner  (pick_onehot),
    .index   (pick_index),
    .valid   (pick_valid)
  );

  always_comb begin
    pick_word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_index == IDW'(i)) begin
        pick_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    owner_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      owner_onehot[i] = (active_id == IDW'(i));
    end
  end

  // Pulse outputs default low every cycle; each state only raises the ones it owns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ARB_RST_STATE;
      pointer      <= PTR_RST;
      start_cnt    <= '0;
      gnt          <= '0;
      done         <= '0;
      uart_tx_req  <= ARB_RST_FLAG;
      uart_tx_data <= '0;
      active_id    <= '0;
      arb_busy     <= ARB_RST_FLAG;
      timeout_err  <= ARB_RST_FLAG;
    end else begin
      gnt         <= '0;
      done        <= '0;
      uart_tx_req <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid && !uart_tx_busy) begin
            uart_tx_data <= pick_word;
            active_id    <= pick_index;
            pointer      <= pick_index;
            gnt          <= pick_onehot;
            uart_tx_req  <= 1'b1;
            arb_busy     <= 1'b1;
            state        <= LAUNCH;
          end
        end
        LAUNCH: begin
          start_cnt <= '0;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (uart_tx_busy) begin
            state <= WAIT_DONE;
          end else if (start_cnt == CNT_LIMIT) begin
            timeout_err <= 1'b1;
            arb_busy    <= 1'b0;
            start_cnt   <= '0;
            state       <= IDLE;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!uart_tx_busy) begin
            done     <= owner_onehot;
            arb_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART busy model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NR-1:0]    req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    done;
  logic [DW-1:0]    uart_tx_data;
  logic             uart_tx_req;
  logic             uart_tx_busy;
  logic [1:0]       active_id;
  logic             arb_busy;
  logic             timeout_err;

  int checks = 0;
  int failures = 0;

  // UART model: busy rises the edge after uart_tx_req and stays high frame_len cycles.
  int   frame_len = 3;
  logic no_ack = 1'b0;
  logic force_busy = 1'b0;
  logic model_busy;
  int   busy_cnt;

  assign uart_tx_busy = model_busy | force_busy;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_busy <= 1'b0;
      busy_cnt   <= 0;
    end else if (uart_tx_req && !no_ack) begin
      model_busy <= 1'b1;
      busy_cnt   <= frame_len - 1;
    end else if (model_busy) begin
      if (busy_cnt == 0) model_busy <= 1'b0;
      else busy_cnt <= busy_cnt - 1;
    end
  end

  uart_tx_arbiter #(
    .NUM_REQ       (NR),
    .DATA_WIDTH    (DW),
    .START_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .done         (done),
    .uart_tx_data (uart_tx_data),
    .uart_tx_req  (uart_tx_req),
    .uart_tx_busy (uart_tx_busy),
    .active_id    (active_id),
    .arb_busy     (arb_busy),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_words;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'hC0DE_0000 | i;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    req = '0;
    no_ack = 1'b0;
    force_busy = 1'b0;
    frame_len = 3;
    set_words();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (done !== 4'b0) begin failures++; $display("FAIL reset_done got=%b exp=0000", done); end
    checks++; if (uart_tx_req !== 1'b0) begin failures++; $display("FAIL reset_tx_req got=%b exp=0", uart_tx_req); end
    checks++; if (uart_tx_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", uart_tx_data); end
    checks++; if (active_id !== 2'd0) begin failures++; $display("FAIL reset_active_id got=%0d exp=0", active_id); end
    checks++; if (arb_busy !== 1'b0) begin failures++; $display("FAIL reset_arb_busy got=%b exp=0", arb_busy); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
  endtask

  task automatic test_single;
    int n;
    do_reset();
    frame_len = 35;
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    checks++; if (uart_tx_req !== 1'b1) begin failures++; $display("FAIL single_tx_req got=%b exp=1", uart_tx_req); end
    checks++; if (uart_tx_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=deadbeef", uart_tx_data); end
    checks++; if (active_id !== 2'd2) begin failures++; $display("FAIL single_active_id got=%0d exp=2", active_id); end
    checks++; if (arb_busy !== 1'b1) begin failures++; $display("FAIL single_arb_busy got=%b exp=1", arb_busy); end
    req = '0;
    req_data[2*DW +: DW] = 32'h0BAD_F00D;
    tick();
    checks++; if (gnt !== 4'b0 || uart_tx_req !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b/%b exp=0000/0", gnt, uart_tx_req); end
    n = 1;
    while (n < 100 && done === 4'b0) begin tick(); n++; end
    // busy occupies 35 cycles starting two edges after grant; done follows the low sample.
    checks++; if (n !== 37) begin failures++; $display("FAIL single_done_latency got=%0d exp=37", n); end
    checks++; if (done !== 4'b0100) begin failures++; $display("FAIL single_done got=%b exp=0100", done); end
    checks++; if (uart_tx_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data_hold got=%h exp=deadbeef", uart_tx_data); end
    checks++; if (arb_busy !== 1'b0) begin failures++; $display("FAIL single_idle_after got=%b exp=0", arb_busy); end
  endtask

  task automatic test_round_robin;
    int exp_id[5] = '{0, 1, 2, 3, 0};
    int k;
    int gap;
    logic [NR-1:0] eg;
    do_reset();
    req = 4'b1111;
    k = 0;
    gap = 0;
    for (int t = 0; t < 200 && k < 5; t++) begin
      tick();
      gap++;
      if (gnt !== 4'b0) begin
        eg = 4'b0001 << exp_id[k];
        checks++; if (gnt !== eg) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, gnt, eg); end
        checks++; if (uart_tx_data !== (32'hC0DE_0000 | exp_id[k])) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, uart_tx_data, 32'hC0DE_0000 | exp_id[k]); end
        checks++; if (gap !== ((k == 0) ? 1 : 6)) begin failures++; $display("FAIL rr_spacing[%0d] got=%0d exp=%0d", k, gap, (k == 0) ? 1 : 6); end
        k++;
        gap = 0;
      end
    end
    checks++; if (k !== 5) begin failures++; $display("FAIL rr_grant_count got=%0d exp=5", k); end
    req = '0;
  endtask

  task automatic test_starvation;
    int exp_id[5] = '{0, 3, 0, 1, 3};
    int k;
    logic [NR-1:0] eg;
    do_reset();
    req = 4'b1001;
    k = 0;
    for (int t = 0; t < 200 && k < 5; t++) begin
      tick();
      if (gnt !== 4'b0) begin
        eg = 4'b0001 << exp_id[k];
        checks++; if (gnt !== eg) begin failures++; $display("FAIL starve_gnt[%0d] got=%b exp=%b", k, gnt, eg); end
        if (k == 1) req[1] = 1'b1;
        if (k == 3) req[1] = 1'b0;
        k++;
      end
    end
    checks++; if (k !== 5) begin failures++; $display("FAIL starve_grant_count got=%0d exp=5", k); end
    req = '0;
  endtask

  task automatic test_timeout;
    int n;
    logic saw_done;
    do_reset();
    no_ack = 1'b1;
    req = 4'b0011;
    tick();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL to_first_gnt got=%b exp=0001", gnt); end
    n = 0;
    saw_done = 1'b0;
    while (n < 50 && timeout_err !== 1'b1) begin
      tick(); n++;
      if (done !== 4'b0) saw_done = 1'b1;
    end
    checks++; if (n !== 5) begin failures++; $display("FAIL to_latency got=%0d exp=5", n); end
    checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL to_no_done got=%b exp=0", saw_done); end
    checks++; if (arb_busy !== 1'b0) begin failures++; $display("FAIL to_arb_busy got=%b exp=0", arb_busy); end
    no_ack = 1'b0;
    tick();
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_pulse_width got=%b exp=0", timeout_err); end
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL to_next_gnt got=%b exp=0010", gnt); end
    req = '0;
    n = 0;
    while (n < 50 && done === 4'b0) begin tick(); n++; end
    checks++; if (done !== 4'b0010) begin failures++; $display("FAIL to_next_done got=%b exp=0010", done); end
  endtask

  task automatic test_reset_mid_frame;
    do_reset();
    frame_len = 35;
    req = 4'b0100;
    tick();
    req = '0;
    repeat (5) tick();
    checks++; if (arb_busy !== 1'b1 || uart_tx_busy !== 1'b1) begin failures++; $display("FAIL mid_in_frame got=%b/%b exp=1/1", arb_busy, uart_tx_busy); end
    reset = 1'b0;
    #1;
    checks++; if (arb_busy !== 1'b0) begin failures++; $display("FAIL mid_arb_busy got=%b exp=0", arb_busy); end
    checks++; if (uart_tx_data !== 32'h0) begin failures++; $display("FAIL mid_data got=%h exp=0", uart_tx_data); end
    checks++; if (active_id !== 2'd0) begin failures++; $display("FAIL mid_active_id got=%0d exp=0", active_id); end
    checks++; if (done !== 4'b0 || gnt !== 4'b0) begin failures++; $display("FAIL mid_pulses got=%b/%b exp=0000/0000", done, gnt); end
    tick();
    reset = 1'b1;
    frame_len = 3;
    req = 4'b1111;
    tick();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL mid_first_after got=%b exp=0001", gnt); end
    req = '0;
  endtask

  task automatic test_busy_idle;
    int bad;
    do_reset();
    force_busy = 1'b1;
    req = 4'b0001;
    bad = 0;
    repeat (6) begin
      tick();
      if (gnt !== 4'b0 || arb_busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL busy_idle_held got=%0d exp=0", bad); end
    force_busy = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL busy_idle_gnt got=%b exp=0001", gnt); end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_starvation();
    test_timeout();
    test_reset_mid_frame();
    test_busy_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter among `NUM_REQ` requesters. It selects one pending requester, latches its word, issues a one-cycle transmit request to the UART, and tracks the UART busy flag until the frame completes. A start timeout recovers the arbiter if the UART never acknowledges. It sits between the client blocks and the UART `TxData`/`TxReq`/`TxBusy` ports.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 32: word width, matches the UART data width.
- `START_TIMEOUT`, 4: cycles allowed for `uart_tx_busy` to rise after launch, 1..255.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester transmit request, level, held until `gnt` or withdrawn.
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed words, requester i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `gnt`  out  NUM_REQ  one-hot, one-cycle pulse: word of requester i captured.
- `done`  out  NUM_REQ  one-hot, one-cycle pulse: frame of requester i finished on the line.
- `uart_tx_data`  out  DATA_WIDTH  word to UART, registered.
- `uart_tx_req`  out  1  one-cycle launch pulse to UART.
- `uart_tx_busy`  in  1  UART transmitter busy flag.
- `active_id`  out  $clog2(NUM_REQ)  index of the current owner, valid while `arb_busy`.
- `arb_busy`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  one-cycle pulse on start timeout.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: if `|req` and `uart_tx_busy==0`, pick the winner. Then latch `req_data` of the winner into `uart_tx_data`, set `active_id`, update the pointer to the winner, and go to LAUNCH. If `uart_tx_busy==1` in IDLE, do not launch.
- Round-robin: search starts at `pointer+1` modulo NUM_REQ. The first set `req` bit wins. The pointer reset value is NUM_REQ-1, so index 0 has first priority.
- LAUNCH: lasts exactly one cycle. `uart_tx_req=1` and `gnt[active_id]=1`. Go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY: if `uart_tx_busy==1`, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches START_TIMEOUT, pulse `timeout_err`, go to IDLE, and give no `done` pulse.
- WAIT_DONE: when `uart_tx_busy==0`, pulse `done[active_id]` and go to IDLE.
- `uart_tx_data` holds stable from LAUNCH until the next capture. It is never modified mid-frame.
- Withdrawing `req` before `gnt` is legal. The requester is then not served. `req` seen outside IDLE is ignored until the next IDLE cycle.
- The pointer advances on every grant, including grants that later time out, so the starvation bound is NUM_REQ-1 frames.

## Timing
- Reset (asynchronous assert) drives these values: state IDLE, pointer NUM_REQ-1, `gnt=0`, `done=0`, `uart_tx_req=0`, `uart_tx_data=0`, `active_id=0`, `arb_busy=0`, `timeout_err=0`, counter 0.
- Reset mid-frame aborts immediately with no `done` pulse. The UART is reset by the same signal.
- Request sampled in IDLE at edge T. LAUNCH (`gnt`, `uart_tx_req`) is high for the cycle after T. `arb_busy` rises at the same edge.
- `done` fires one cycle after `uart_tx_busy` is sampled low in WAIT_DONE. The next grant fires one cycle after that.
- Minimum spacing between back-to-back launches is frame length + 3 cycles.
- All outputs are registered. There is no combinational path from `req` or `uart_tx_busy` to any output.

## Structure
- Shared package `uart_pkg`:
  - `DATA_WIDTH` default.
  - `arb_state_t` enum {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE}.
  - Reset-value constants.
- Sub-module `rr_priority_pick`: combinational round-robin search.
  - Inputs: `req` and pointer.
  - Outputs: one-hot winner, winner index, valid.
- Top level: FSM, data latch, timeout counter.

## Test plan
- Single request: `req=4'b0100`, `req_data[2]=32'hDEADBEEF`, UART model busy 35 cycles → `gnt=4'b0100` one cycle after the request, `uart_tx_data=32'hDEADBEEF`, `done=4'b0100` one cycle after busy falls.
- Simultaneous requests: `req=4'b1111` held, served in order 0,1,2,3,0. Each `gnt` is one-hot with no overlap.
- Starvation: requesters 0 and 3 continuously re-request → grants alternate 0,3,0,3. Requester 1 raises `req` mid-stream and is granted within ≤3 frames.
- Timeout: UART model never raises busy, START_TIMEOUT=4 → `timeout_err` pulses 4 cycles after WAIT_BUSY entry, no `done`, pointer advanced, next requester served.
- Reset mid-frame: assert `reset=0` during WAIT_DONE → all outputs are at reset values asynchronously. After release, index 0 wins first.
- Busy in IDLE: `uart_tx_busy=1` with `req=4'b0001` → no `gnt` until busy is low. Then `gnt=4'b0001` one cycle after the low sample.
